tl_uncached_acquire_arbiter: RTL and testbench

- Shares one uncached TileLink outer port (acquire/grant, 128-bit beats, 4 beats per block) between N_CLIENTS inner requesters.
- Sits in front of the RapidIO bridge inner port, so several agents (core MMIO, DMA, debug) reach the link through one channel.
- Arbitrates acquires round-robin and holds the grant across multi-beat putBlock bursts.
- Tags the outgoing xact id with the winning client index and routes grants back by that tag.

---
 rtl/tl_uncached_pkg.sv | 22 ++
 rtl/tl_uncached_acquire_arbiter_rr_priority_picker.sv | 31 +++
 rtl/tl_uncached_acquire_arbiter.sv | 150 +++++++++++++++
 tb/tb_tl_uncached_acquire_arbiter.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tl_uncached_pkg.sv
// Shared TileLink uncached field widths, acquire type codes and beat helpers.
package tl_uncached_pkg;

  localparam int ADDR_BLOCK_W = 26;
  localparam int UNION_W      = 17;
  localparam int DATA_W       = 128;
  localparam int BEAT_W       = 2;

  typedef enum logic [2:0] {
    GET        = 3'd0,
    GET_BLOCK  = 3'd1,
    PUT        = 3'd2,
    PUT_BLOCK  = 3'd3,
    PUT_ATOMIC = 3'd4
  } a_type_e;

  // Only a built-in putBlock carries a multi-beat payload on the acquire channel.
  function automatic logic has_multibeat_data(input logic is_builtin, input logic [2:0] a_type);
    return is_builtin && (a_type == PUT_BLOCK);
  endfunction

endpackage

// File: rtl/tl_uncached_acquire_arbiter_rr_priority_picker.sv
// Round-robin picker: first valid requester at or after ptr, as one-hot and index.
module rr_priority_picker #(
  parameter int N_CLIENTS = 2,
  parameter int IDX_W     = 1
) (
  input  logic [N_CLIENTS-1:0] valid,
  input  logic [IDX_W-1:0]     ptr,
  output logic [N_CLIENTS-1:0] onehot,
  output logic [IDX_W-1:0]     idx,
  output logic                 any
);

  int cand;

  always_comb begin
    onehot = '0;
    idx    = '0;
    any    = |valid;
    cand   = 0;
    // Scan from the farthest offset down so the nearest valid client wins last.
    for (int off = N_CLIENTS - 1; off >= 0; off--) begin
      cand = (int'(ptr) + off) % N_CLIENTS;
      if (valid[cand]) begin
        onehot       = '0;
        onehot[cand] = 1'b1;
        idx          = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/tl_uncached_acquire_arbiter.sv
// N-to-1 uncached TileLink acquire arbiter with putBlock burst lock and tag-routed grants.
module tl_uncached_acquire_arbiter
  import tl_uncached_pkg::*;
#(
  parameter int N_CLIENTS = 2,
  parameter int IDX_W     = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1,
  parameter int XID_W     = 2,
  parameter int BEATS     = 4
) (
  input  logic                           clock,
  input  logic                           reset,

  input  logic [N_CLIENTS-1:0]           in_acquire_valid,
  output logic [N_CLIENTS-1:0]           in_acquire_ready,
  input  logic [N_CLIENTS*XID_W-1:0]     in_acquire_bits_client_xact_id,
  input  logic [N_CLIENTS-1:0]           in_acquire_bits_is_builtin_type,
  input  logic [N_CLIENTS*3-1:0]         in_acquire_bits_a_type,
  input  logic [N_CLIENTS*ADDR_BLOCK_W-1:0] in_acquire_bits_addr_block,
  input  logic [N_CLIENTS*BEAT_W-1:0]    in_acquire_bits_addr_beat,
  input  logic [N_CLIENTS*UNION_W-1:0]   in_acquire_bits_union,
  input  logic [N_CLIENTS*DATA_W-1:0]    in_acquire_bits_data,

  output logic [N_CLIENTS-1:0]           in_grant_valid,
  input  logic [N_CLIENTS-1:0]           in_grant_ready,
  output logic [XID_W-1:0]               in_grant_bits_client_xact_id,
  output logic                           in_grant_bits_manager_xact_id,
  output logic                           in_grant_bits_is_builtin_type,
  output logic [3:0]                     in_grant_bits_g_type,
  output logic [BEAT_W-1:0]              in_grant_bits_addr_beat,
  output logic [DATA_W-1:0]              in_grant_bits_data,

  output logic                           out_acquire_valid,
  input  logic                           out_acquire_ready,
  output logic [IDX_W+XID_W-1:0]         out_acquire_bits_client_xact_id,
  output logic                           out_acquire_bits_is_builtin_type,
  output logic [2:0]                     out_acquire_bits_a_type,
  output logic [ADDR_BLOCK_W-1:0]        out_acquire_bits_addr_block,
  output logic [BEAT_W-1:0]              out_acquire_bits_addr_beat,
  output logic [UNION_W-1:0]             out_acquire_bits_union,
  output logic [DATA_W-1:0]              out_acquire_bits_data,

  input  logic                           out_grant_valid,
  output logic                           out_grant_ready,
  input  logic [IDX_W+XID_W-1:0]         out_grant_bits_client_xact_id,
  input  logic                           out_grant_bits_manager_xact_id,
  input  logic                           out_grant_bits_is_builtin_type,
  input  logic [3:0]                     out_grant_bits_g_type,
  input  logic [BEAT_W-1:0]              out_grant_bits_addr_beat,
  input  logic [DATA_W-1:0]              out_grant_bits_data
);

  logic [IDX_W-1:0]     rr_ptr;
  logic                 locked;
  logic [IDX_W-1:0]     lock_idx;
  logic [BEAT_W-1:0]    beat_cnt;

  logic [N_CLIENTS-1:0] pick_onehot;
  logic [IDX_W-1:0]     pick_idx;
  logic                 pick_any;
  logic [IDX_W-1:0]     sel_idx;
  logic                 acq_fire;
  logic                 sel_multibeat;

  logic [IDX_W-1:0]     g_idx;
  logic [N_CLIENTS-1:0] grant_hit;

  rr_priority_picker #(
    .N_CLIENTS (N_CLIENTS),
    .IDX_W     (IDX_W)
  ) u_picker (
    .valid  (in_acquire_valid),
    .ptr    (rr_ptr),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  assign sel_idx           = locked ? lock_idx : pick_idx;
  assign out_acquire_valid = locked ? in_acquire_valid[sel_idx] : pick_any;
  assign acq_fire          = out_acquire_valid && out_acquire_ready;

  always_comb begin
    int s;
    s = int'(sel_idx);
    out_acquire_bits_client_xact_id  = {sel_idx, in_acquire_bits_client_xact_id[s*XID_W +: XID_W]};
    out_acquire_bits_is_builtin_type = in_acquire_bits_is_builtin_type[s];
    out_acquire_bits_a_type          = in_acquire_bits_a_type[s*3 +: 3];
    out_acquire_bits_addr_block      = in_acquire_bits_addr_block[s*ADDR_BLOCK_W +: ADDR_BLOCK_W];
    out_acquire_bits_addr_beat       = in_acquire_bits_addr_beat[s*BEAT_W +: BEAT_W];
    out_acquire_bits_union           = in_acquire_bits_union[s*UNION_W +: UNION_W];
    out_acquire_bits_data            = in_acquire_bits_data[s*DATA_W +: DATA_W];
  end

  assign sel_multibeat = has_multibeat_data(out_acquire_bits_is_builtin_type, out_acquire_bits_a_type);
  assign g_idx         = out_grant_bits_client_xact_id[IDX_W+XID_W-1 -: IDX_W];

  genvar gi;
  generate
    for (gi = 0; gi < N_CLIENTS; gi++) begin : g_client
      assign in_acquire_ready[gi] = out_acquire_ready &&
                                    (locked ? (lock_idx == IDX_W'(gi)) : pick_onehot[gi]);
      assign grant_hit[gi]        = (g_idx == IDX_W'(gi));
      assign in_grant_valid[gi]   = out_grant_valid && grant_hit[gi];
    end
  endgenerate

  // A tag naming no client is drained so the outer port never stalls on it.
  assign out_grant_ready = (|(grant_hit & in_grant_ready)) || !(|grant_hit);

  assign in_grant_bits_client_xact_id  = out_grant_bits_client_xact_id[XID_W-1:0];
  assign in_grant_bits_manager_xact_id = out_grant_bits_manager_xact_id;
  assign in_grant_bits_is_builtin_type = out_grant_bits_is_builtin_type;
  assign in_grant_bits_g_type          = out_grant_bits_g_type;
  assign in_grant_bits_addr_beat       = out_grant_bits_addr_beat;
  assign in_grant_bits_data            = out_grant_bits_data;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rr_ptr   <= '0;
      locked   <= 1'b0;
      lock_idx <= '0;
      beat_cnt <= '0;
    end else if (acq_fire) begin
      if (locked) begin
        if (beat_cnt == BEAT_W'(BEATS - 1)) begin
          locked   <= 1'b0;
          beat_cnt <= '0;
        end else begin
          beat_cnt <= beat_cnt + 1'b1;
        end
      end else begin
        rr_ptr <= (pick_idx == IDX_W'(N_CLIENTS - 1)) ? '0 : pick_idx + 1'b1;
        if (sel_multibeat) begin
          locked   <= 1'b1;
          lock_idx <= pick_idx;
          beat_cnt <= BEAT_W'(1);
        end
      end
    end
  end

`ifndef SYNTHESIS
  always @(posedge clock) begin
    if (!reset) begin
      assert (!(out_grant_valid && !(|grant_hit)));
    end
  end
`endif

endmodule

// File: tb/tb_tl_uncached_acquire_arbiter.sv
// Randomized and directed bench for the acquire arbiter against a queue-free burst model.
module tb_tl_uncached_acquire_arbiter;

  localparam int N = 2;
  localparam int XID_W = 2;
  localparam int IDX_W = 1;
  localparam int IDW = IDX_W + XID_W;

  logic clock = 1'b0;
  logic reset;

  logic [N-1:0]       in_acquire_valid, in_acquire_ready;
  logic [N*XID_W-1:0] in_acquire_bits_client_xact_id;
  logic [N-1:0]       in_acquire_bits_is_builtin_type;
  logic [N*3-1:0]     in_acquire_bits_a_type;
  logic [N*26-1:0]    in_acquire_bits_addr_block;
  logic [N*2-1:0]     in_acquire_bits_addr_beat;
  logic [N*17-1:0]    in_acquire_bits_union;
  logic [N*128-1:0]   in_acquire_bits_data;
  logic [N-1:0]       in_grant_valid, in_grant_ready;
  logic [XID_W-1:0]   in_grant_bits_client_xact_id;
  logic               in_grant_bits_manager_xact_id, in_grant_bits_is_builtin_type;
  logic [3:0]         in_grant_bits_g_type;
  logic [1:0]         in_grant_bits_addr_beat;
  logic [127:0]       in_grant_bits_data;
  logic               out_acquire_valid, out_acquire_ready;
  logic [IDW-1:0]     out_acquire_bits_client_xact_id;
  logic               out_acquire_bits_is_builtin_type;
  logic [2:0]         out_acquire_bits_a_type;
  logic [25:0]        out_acquire_bits_addr_block;
  logic [1:0]         out_acquire_bits_addr_beat;
  logic [16:0]        out_acquire_bits_union;
  logic [127:0]       out_acquire_bits_data;
  logic               out_grant_valid, out_grant_ready;
  logic [IDW-1:0]     out_grant_bits_client_xact_id;
  logic               out_grant_bits_manager_xact_id, out_grant_bits_is_builtin_type;
  logic [3:0]         out_grant_bits_g_type;
  logic [1:0]         out_grant_bits_addr_beat;
  logic [127:0]       out_grant_bits_data;

  tl_uncached_acquire_arbiter #(.N_CLIENTS(N), .IDX_W(IDX_W), .XID_W(XID_W), .BEATS(4)) dut (
    .clock(clock), .reset(reset),
    .in_acquire_valid(in_acquire_valid), .in_acquire_ready(in_acquire_ready),
    .in_acquire_bits_client_xact_id(in_acquire_bits_client_xact_id),
    .in_acquire_bits_is_builtin_type(in_acquire_bits_is_builtin_type),
    .in_acquire_bits_a_type(in_acquire_bits_a_type),
    .in_acquire_bits_addr_block(in_acquire_bits_addr_block),
    .in_acquire_bits_addr_beat(in_acquire_bits_addr_beat),
    .in_acquire_bits_union(in_acquire_bits_union),
    .in_acquire_bits_data(in_acquire_bits_data),
    .in_grant_valid(in_grant_valid), .in_grant_ready(in_grant_ready),
    .in_grant_bits_client_xact_id(in_grant_bits_client_xact_id),
    .in_grant_bits_manager_xact_id(in_grant_bits_manager_xact_id),
    .in_grant_bits_is_builtin_type(in_grant_bits_is_builtin_type),
    .in_grant_bits_g_type(in_grant_bits_g_type),
    .in_grant_bits_addr_beat(in_grant_bits_addr_beat),
    .in_grant_bits_data(in_grant_bits_data),
    .out_acquire_valid(out_acquire_valid), .out_acquire_ready(out_acquire_ready),
    .out_acquire_bits_client_xact_id(out_acquire_bits_client_xact_id),
    .out_acquire_bits_is_builtin_type(out_acquire_bits_is_builtin_type),
    .out_acquire_bits_a_type(out_acquire_bits_a_type),
    .out_acquire_bits_addr_block(out_acquire_bits_addr_block),
    .out_acquire_bits_addr_beat(out_acquire_bits_addr_beat),
    .out_acquire_bits_union(out_acquire_bits_union),
    .out_acquire_bits_data(out_acquire_bits_data),
    .out_grant_valid(out_grant_valid), .out_grant_ready(out_grant_ready),
    .out_grant_bits_client_xact_id(out_grant_bits_client_xact_id),
    .out_grant_bits_manager_xact_id(out_grant_bits_manager_xact_id),
    .out_grant_bits_is_builtin_type(out_grant_bits_is_builtin_type),
    .out_grant_bits_g_type(out_grant_bits_g_type),
    .out_grant_bits_addr_beat(out_grant_bits_addr_beat),
    .out_grant_bits_data(out_grant_bits_data)
  );

  always #5 clock = ~clock;

  int total = 0;
  int passed = 0;

  // Reference model: who has priority next, and who owns an unfinished block write.
  int m_ptr;
  int m_owner;
  int m_left;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_ptr = 0; m_owner = -1; m_left = 0;
  endtask

  task automatic set_client(input int i, input logic v, input logic bi, input logic [2:0] t,
                            input logic [XID_W-1:0] x, input logic [127:0] d);
    in_acquire_valid[i]                      = v;
    in_acquire_bits_is_builtin_type[i]       = bi;
    in_acquire_bits_a_type[i*3 +: 3]         = t;
    in_acquire_bits_client_xact_id[i*XID_W +: XID_W] = x;
    in_acquire_bits_addr_block[i*26 +: 26]   = 26'($urandom);
    in_acquire_bits_addr_beat[i*2 +: 2]      = 2'($urandom);
    in_acquire_bits_union[i*17 +: 17]        = 17'($urandom);
    in_acquire_bits_data[i*128 +: 128]       = d;
  endtask

  task automatic set_grant(input logic v, input logic [IDW-1:0] id, input logic [N-1:0] rdy);
    out_grant_valid                = v;
    out_grant_bits_client_xact_id  = id;
    in_grant_ready                 = rdy;
    out_grant_bits_manager_xact_id = 1'($urandom);
    out_grant_bits_is_builtin_type = 1'($urandom);
    out_grant_bits_g_type          = 4'($urandom);
    out_grant_bits_addr_beat       = 2'($urandom);
    out_grant_bits_data            = {$urandom, $urandom, $urandom, $urandom};
  endtask

  // Called 1 time unit after a rising edge: checks the combinational outputs,
  // then advances through the next edge and updates the model.
  task automatic cycle();
    int sel;
    bit ev, fire, pb;
    logic [N-1:0] er, egv;
    int g;
    #3;
    sel = -1;
    if (m_owner >= 0) begin
      sel = m_owner;
      ev = in_acquire_valid[sel];
    end else begin
      for (int k = 0; k < N; k++) begin
        if (sel < 0 && in_acquire_valid[(m_ptr + k) % N]) sel = (m_ptr + k) % N;
      end
      ev = (sel >= 0);
    end
    er = (ev && out_acquire_ready) ? N'(1 << sel) : '0;
    chk("acq_valid", out_acquire_valid, ev);
    chk("acq_ready", in_acquire_ready & in_acquire_valid, er);
    if (ev) begin
      chk("acq_id", out_acquire_bits_client_xact_id,
          {IDX_W'(sel), in_acquire_bits_client_xact_id[sel*XID_W +: XID_W]});
      chk("acq_type", out_acquire_bits_a_type, in_acquire_bits_a_type[sel*3 +: 3]);
      chk("acq_addr", out_acquire_bits_addr_block, in_acquire_bits_addr_block[sel*26 +: 26]);
      chk("acq_data", out_acquire_bits_data, in_acquire_bits_data[sel*128 +: 128]);
    end
    g   = int'(out_grant_bits_client_xact_id[IDW-1 -: IDX_W]);
    egv = out_grant_valid ? N'(1 << g) : '0;
    chk("gnt_valid", in_grant_valid, egv);
    chk("gnt_ready", out_grant_ready, in_grant_ready[g]);
    chk("gnt_id", in_grant_bits_client_xact_id, out_grant_bits_client_xact_id[XID_W-1:0]);
    chk("gnt_data", in_grant_bits_data, out_grant_bits_data);
    fire = ev && out_acquire_ready;
    pb = (sel >= 0) && in_acquire_bits_is_builtin_type[sel] &&
         (in_acquire_bits_a_type[sel*3 +: 3] == 3'd3);
    @(posedge clock);
    if (fire) begin
      if (m_owner >= 0) begin
        m_left--;
        if (m_left == 0) m_owner = -1;
      end else begin
        m_ptr = (sel + 1) % N;
        if (pb) begin m_owner = sel; m_left = 3; end
      end
    end
    #1;
  endtask

  initial begin
    reset = 1'b1;
    in_acquire_valid = '0; in_acquire_bits_client_xact_id = '0;
    in_acquire_bits_is_builtin_type = '0; in_acquire_bits_a_type = '0;
    in_acquire_bits_addr_block = '0; in_acquire_bits_addr_beat = '0;
    in_acquire_bits_union = '0; in_acquire_bits_data = '0;
    out_acquire_ready = 1'b1;
    set_grant(1'b0, '0, '0);
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    chk("rst_acq_valid", out_acquire_valid, 1'b0);
    chk("rst_gnt_valid", in_grant_valid, 2'b00);
    reset = 1'b0;

    // Lone Get from client 0 and its tagged grant.
    set_client(0, 1, 1, 3'd0, 2'd2, 128'h1234);
    set_client(1, 0, 1, 3'd0, 2'd0, 128'h0);
    set_grant(1'b1, 3'b010, 2'b11);
    #2;
    chk("t1_out_id", out_acquire_bits_client_xact_id, 3'b010);
    chk("t1_gnt_valid", in_grant_valid, 2'b01);
    chk("t1_gnt_id", in_grant_bits_client_xact_id, 2'd2);
    #(-0);
    cycle();
    set_grant(1'b0, '0, 2'b11);

    // Two steady Get sources alternate.
    set_client(0, 1, 1, 3'd0, 2'd1, 128'hA0);
    set_client(1, 1, 1, 3'd2, 2'd3, 128'hB1);
    repeat (4) cycle();

    // Client 1 block write with client 0 pending.
    model_reset();
    reset = 1'b1; #1; reset = 1'b0;
    set_client(0, 1, 1, 3'd0, 2'd0, 128'hC0);
    set_client(1, 0, 1, 3'd0, 2'd0, 128'h0);
    cycle();
    set_client(1, 1, 1, 3'd3, 2'd1, 128'hD0);
    repeat (5) cycle();

    // Block write under a stuttering outer ready.
    set_client(1, 0, 1, 3'd0, 2'd0, 128'h0);
    set_client(0, 1, 1, 3'd3, 2'd2, 128'hE0);
    for (int i = 0; i < 10; i++) begin
      out_acquire_ready = (i % 2 == 0);
      cycle();
    end
    out_acquire_ready = 1'b1;

    // Grant to client 1 back-pressured for three cycles.
    set_grant(1'b1, 3'b101, 2'b01);
    repeat (3) cycle();
    set_grant(1'b1, 3'b101, 2'b11);
    cycle();
    set_grant(1'b0, '0, 2'b11);

    // Reset after two beats of a block write: lock dropped, client 0 first.
    set_client(0, 0, 1, 3'd0, 2'd0, 128'h0);
    set_client(1, 1, 1, 3'd3, 2'd0, 128'hF0);
    repeat (2) cycle();
    set_client(0, 1, 1, 3'd0, 2'd1, 128'hF1);
    reset = 1'b1; #1;
    model_reset();
    chk("rst_mid_ready", in_acquire_ready, 2'b01);
    reset = 1'b0;
    cycle();
    cycle();

    // Random traffic.
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < N; i++) begin
        set_client(i, ($urandom % 3) != 0, ($urandom % 4) != 0, 3'($urandom_range(0, 4)),
                   2'($urandom), {$urandom, $urandom, $urandom, $urandom});
      end
      out_acquire_ready = ($urandom % 4) != 0;
      set_grant(1'($urandom), 3'($urandom), 2'($urandom));
      cycle();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
